// File: rtl/sitcp_tx_framer_if.sv
`default_nettype none
// ============================================================================
// sitcp_tx_framer_if : byte-source channels, SiTCP TX port and framer status
// Revision: 1.0
// ============================================================================
interface sitcp_tx_framer_if #(
  parameter int N_CH = 4
);
  logic              TCP_OPEN_ACK;
  logic [N_CH-1:0]   CH_EN;
  logic [N_CH-1:0]   CH_VALID;
  logic [8*N_CH-1:0] CH_DATA;
  logic [N_CH-1:0]   CH_LAST;
  logic [N_CH-1:0]   CH_READY;
  logic              TCP_TX_FULL;
  logic              TCP_TX_WR;
  logic [7:0]        TCP_TX_DATA;
  logic              BUSY;
  logic [31:0]       FRAME_CNT;
  logic [15:0]       ABORT_CNT;

  modport master (
    input  TCP_OPEN_ACK, CH_EN, CH_VALID, CH_DATA, CH_LAST, TCP_TX_FULL,
    output CH_READY, TCP_TX_WR, TCP_TX_DATA, BUSY, FRAME_CNT, ABORT_CNT
  );

  modport slave (
    output TCP_OPEN_ACK, CH_EN, CH_VALID, CH_DATA, CH_LAST, TCP_TX_FULL,
    input  CH_READY, TCP_TX_WR, TCP_TX_DATA, BUSY, FRAME_CNT, ABORT_CNT
  );
endinterface
`default_nettype wire

// File: rtl/sitcp_tx_framer.sv
`default_nettype none
// ============================================================================
// sitcp_tx_framer : round-robin framer of N_CH byte streams onto SiTCP TX
// Revision: 1.0
// ============================================================================
module sitcp_tx_framer #(
  parameter int N_CH    = 4,
  parameter int BURST   = 64,
  parameter int IDLE_TO = 1024
) (
  input wire                CLK,
  input wire                RSTn,
  sitcp_tx_framer_if.master bus
);

  localparam int SW = $clog2(IDLE_TO + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR0    = 3'd1,
    HDR1    = 3'd2,
    PAYLOAD = 3'd3,
    TRAILER = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    grant;
  logic [3:0]    last_grant;
  logic [7:0]    pay_cnt;
  logic [SW-1:0] stall_cnt;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic [31:0]   frame_cnt;
  logic [15:0]   abort_cnt;

  logic [15:0]     elig;
  logic [15:0]     valid_w;
  logic [15:0]     last_w;
  logic [N_CH-1:0] grant_oh;
  logic            any_elig;
  logic [3:0]      rr_pick;
  logic            xfer;
  logic [7:0]      xfer_byte;
  logic [7:0]      pay_next;

  // Channel vectors are widened to 16 bits so a 4-bit grant can index them.
  assign elig      = 16'(bus.CH_EN & bus.CH_VALID & {N_CH{bus.TCP_OPEN_ACK}});
  assign valid_w   = 16'(bus.CH_VALID);
  assign last_w    = 16'(bus.CH_LAST);
  assign grant_oh  = N_CH'(1) << grant;
  assign xfer_byte = 8'(bus.CH_DATA >> {grant, 3'b000});
  assign pay_next  = pay_cnt + 8'd1;
  assign xfer      = (state == PAYLOAD) & bus.TCP_OPEN_ACK & ~bus.TCP_TX_FULL & valid_w[grant];

  // Scan farthest-first so the nearest eligible channel after last_grant wins.
  always_comb begin
    any_elig = 1'b0;
    rr_pick  = last_grant;
    for (int k = N_CH; k >= 1; k--) begin
      if (elig[4'((int'(last_grant) + k) % N_CH)]) begin
        any_elig = 1'b1;
        rr_pick  = 4'((int'(last_grant) + k) % N_CH);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state      <= IDLE;
      grant      <= 4'd0;
      last_grant <= 4'(N_CH - 1);
      pay_cnt    <= 8'd0;
      stall_cnt  <= '0;
      tx_wr      <= 1'b0;
      tx_data    <= 8'h00;
      frame_cnt  <= 32'd0;
      abort_cnt  <= 16'd0;
    end else begin
      tx_wr <= 1'b0;
      if (state != IDLE && !bus.TCP_OPEN_ACK) begin
        state <= IDLE;
        if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
      end else begin
        case (state)
          IDLE: begin
            if (any_elig) begin
              grant      <= rr_pick;
              last_grant <= rr_pick;
              pay_cnt    <= 8'd0;
              stall_cnt  <= '0;
              state      <= HDR0;
            end
          end
          HDR0: begin
            if (!bus.TCP_TX_FULL) begin
              tx_wr   <= 1'b1;
              tx_data <= 8'hA5;
              state   <= HDR1;
            end
          end
          HDR1: begin
            if (!bus.TCP_TX_FULL) begin
              tx_wr   <= 1'b1;
              tx_data <= {4'h0, grant};
              state   <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (xfer) begin
              tx_wr     <= 1'b1;
              tx_data   <= xfer_byte;
              pay_cnt   <= pay_next;
              stall_cnt <= '0;
              if (last_w[grant] || pay_next == 8'(BURST)) state <= TRAILER;
            end else if (stall_cnt == SW'(IDLE_TO - 1)) begin
              state <= TRAILER;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end
          TRAILER: begin
            if (!bus.TCP_TX_FULL) begin
              tx_wr     <= 1'b1;
              tx_data   <= pay_cnt;
              frame_cnt <= frame_cnt + 32'd1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.CH_READY    = (state == PAYLOAD && bus.TCP_OPEN_ACK && !bus.TCP_TX_FULL) ? grant_oh : '0;
  assign bus.TCP_TX_WR   = tx_wr;
  assign bus.TCP_TX_DATA = tx_data;
  assign bus.BUSY        = (state != IDLE);
  assign bus.FRAME_CNT   = frame_cnt;
  assign bus.ABORT_CNT   = abort_cnt;

endmodule
`default_nettype wire

// File: doc/sitcp_tx_framer.md
SITCP_TX_FRAMER -- requirements
Module: sitcp_tx_framer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of byte-stream source channels (1..16).
REQ-002 SHALL have parameter BURST, default 64, maximum payload bytes per frame (1..255).
REQ-003 SHALL have parameter IDLE_TO, default 1024, stall cycles in PAYLOAD before a frame is closed early (>=2).
REQ-004 SHALL have port CLK  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port RSTn  in  1  synchronous active-low reset.
REQ-006 SHALL have port TCP_OPEN_ACK  in  1  SiTCP connection open; low = closed.
REQ-007 SHALL have port CH_EN  in  N_CH  per-channel enable mask.
REQ-008 SHALL have port CH_VALID  in  N_CH  per-channel byte valid.
REQ-009 SHALL have port CH_DATA  in  8*N_CH  channel i byte on bits [8i+7:8i].
REQ-010 SHALL have port CH_LAST  in  N_CH  marks the last byte of a source burst.
REQ-011 SHALL have port CH_READY  out  N_CH  per-channel byte accept.
REQ-012 SHALL have port TCP_TX_FULL  in  1  SiTCP TX almost-full.
REQ-013 SHALL have port TCP_TX_WR  out  1  SiTCP TX write enable.
REQ-014 SHALL have port TCP_TX_DATA  out  8  SiTCP TX data.
REQ-015 SHALL have port BUSY  out  1  high whenever the state is not IDLE.
REQ-016 SHALL have port FRAME_CNT  out  32  count of completed frames.
REQ-017 SHALL have port ABORT_CNT  out  16  count of aborted frames.

Function
REQ-018 SHALL implement states IDLE, HDR0, HDR1, PAYLOAD, TRAILER.
REQ-019 Eligible channel: CH_EN[i] & CH_VALID[i] & TCP_OPEN_ACK.
REQ-020 IDLE: if any channel is eligible, SHALL grant by round-robin starting at (last_grant+1) mod N_CH, latch the grant, and go to HDR0 next cycle.
REQ-021 HDR0/HDR1/TRAILER: SHALL emit one byte per cycle only while TCP_TX_FULL=0 and otherwise hold state; bytes are 0xA5, then {4'h0,grant[3:0]}, then the payload count[7:0].
REQ-022 PAYLOAD: CH_READY[grant] = ~TCP_TX_FULL; all other CH_READY bits SHALL be 0; a transfer occurs on CH_VALID&CH_READY.
REQ-023 Every transfer SHALL register TCP_TX_WR=1 and TCP_TX_DATA=byte on the next edge; TCP_TX_WR SHALL be 0 in every cycle with no emission.
REQ-024 The payload counter SHALL increment per transfer; PAYLOAD SHALL exit to TRAILER after a transfer with CH_LAST=1 or when the counter reaches BURST.
REQ-025 The stall counter SHALL reset on each transfer and otherwise increment in PAYLOAD; at IDLE_TO it SHALL go to TRAILER (count >=1 is guaranteed).
REQ-026 TRAILER emission SHALL increment FRAME_CNT by 1 (wraps at 2^32), then go to IDLE; IDLE with an eligible channel re-arbitrates in that same IDLE cycle.
REQ-027 TCP_OPEN_ACK=0 in any non-IDLE state SHALL force IDLE next cycle, drive CH_READY=0, emit nothing further, and increment ABORT_CNT (saturating at 0xFFFF).
REQ-028 CH_EN deasserting for the granted channel mid-frame SHALL NOT abort the frame.
REQ-029 TCP_TX_FULL rising SHALL stop emission in the cycle it is sampled high; no byte SHALL be lost or duplicated.
REQ-030 Source-to-first-byte latency: eligible at cycle t -> 0xA5 on TCP_TX_WR at t+2 when FULL=0.

Reset
REQ-031 RSTn=0 sampled SHALL set state IDLE; TCP_TX_WR=0, TCP_TX_DATA=0x00, CH_READY=0, BUSY=0, FRAME_CNT=0, ABORT_CNT=0, and the payload and stall counters to 0.
REQ-032 Reset SHALL set last_grant=N_CH-1 so channel 0 wins first arbitration.
REQ-033 Reset mid-frame SHALL discard the partial frame without incrementing ABORT_CNT.

Verification
REQ-034 Single channel: ch0 sends 3 bytes 11,22,33 with LAST on 33, FULL=0 -> TX stream A5,00,11,22,33,03; FRAME_CNT=1.
REQ-035 Round-robin: all 4 channels continuously valid with BURST=2 -> header channel IDs 0,1,2,3,0; every trailer =02.
REQ-036 Backpressure: toggle FULL every 3 cycles during a 64-byte burst -> byte order intact; no TX_WR while FULL was sampled high; trailer =40 (hex).
REQ-037 Stall: ch1 sends 5 bytes then VALID=0 for IDLE_TO cycles -> trailer =05; FRAME_CNT increments by 1.
REQ-038 Abort: drop TCP_OPEN_ACK after 10 payload bytes -> no trailer; ABORT_CNT=1; BUSY=0 next cycle; CH_READY=0.
REQ-039 Disabled channel: CH_EN=4'b1101 with all channels valid -> channel 1 is never granted; CH_READY[1] stays 0.
